// File: rtl/coax_pkg.sv
// coax_pkg -- definitions shared by the 3270 coax transmitter and receiver.
//
// Contents:
//   tx_state_t        : transmitter frame-sequencer states
//   QUIESCE_BITS      : number of '1' bits that open a frame
//   CV_LOW_HALVES     : code-violation low half-bits
//   CV_HIGH_HALVES    : code-violation high half-bits
//   WORD_BITS         : payload width of one coax word
//   coax_parity()     : parity bit over sync bit + word (shared with coax_rx)
//   manchester_half() : line level for a bit value in a given half-bit
package coax_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_CODE_VIOL,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_END
  } tx_state_t;

  localparam int QUIESCE_BITS   = 5;
  localparam int CV_LOW_HALVES  = 3;
  localparam int CV_HIGH_HALVES = 3;
  localparam int WORD_BITS      = 10;

  // The leading sync bit (always 1) takes part in the parity.
  function automatic logic coax_parity(input logic [WORD_BITS-1:0] word,
                                       input logic                 even);
    return even ? (^{1'b1, word}) : (~^{1'b1, word});
  endfunction

  // '1' is sent low-then-high, '0' high-then-low.
  function automatic logic manchester_half(input logic bit_val,
                                           input logic first_half);
    return first_half ? ~bit_val : bit_val;
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// coax_tx_bit_timer -- half-bit / bit timing for the coax transmitter.
//
// A counter runs 0..CLOCKS_PER_BIT-1 continuously while a frame is in
// progress and is held at zero while restart is high, so the first frame
// clock is always the first clock of a bit.
//
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   restart      : hold the counter at the start of a bit
//   first_half   : current clock lies in the first half of the bit
//   half_strobe  : last clock of either half-bit
//   bit_strobe   : last clock of the bit
module coax_tx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic first_half,
  output logic half_strobe,
  output logic bit_strobe
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == BIT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign first_half  = (cnt <= HALF_LAST);
  assign half_strobe = (cnt == HALF_LAST) || (cnt == BIT_LAST);
  assign bit_strobe  = (cnt == BIT_LAST);

endmodule

// File: rtl/coax_tx.sv
// coax_tx -- 3270 coax link transmitter.
//
// Serializes 10-bit words into Manchester-coded frames:
//   quiesce (5 x '1'), code violation (3 half-bits low, 3 high),
//   per word: sync '1', 10 data bits MSB first, parity bit,
//   end: sync '0', one full bit high, then line low.
// A one-deep holding register lets back-to-back words share a frame.
//
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   data       : word to send (captured on load while ready)
//   load       : single-cycle strobe
//   ready      : holding register can accept a word
//   parity     : 1 = even, 0 = odd; sampled when a word enters the shifter
//   tx         : registered line output
//   active     : frame in progress (driver enable)
//   tx_delay   : tx delayed CLOCKS_PER_BIT/4 clocks, zero while inactive
//                (only when COAX_TX_DELAY_EN is defined)
//
// CLOCKS_PER_BIT must be a multiple of 4 and at least 4.
module coax_tx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data,
  input  logic                 load,
  output logic                 ready,
  input  logic                 parity,
  output logic                 tx,
  output logic                 active
`ifdef COAX_TX_DELAY_EN
  ,
  output logic                 tx_delay
`endif
);

  localparam logic [3:0] QUIESCE_LAST = 4'(QUIESCE_BITS - 1);
  localparam logic [3:0] CV_LOW_END   = 4'(CV_LOW_HALVES);
  localparam logic [3:0] CV_LAST      = 4'(CV_LOW_HALVES + CV_HIGH_HALVES - 1);
  localparam logic [3:0] DATA_LAST    = 4'(WORD_BITS - 1);
  localparam logic [3:0] END_LAST     = 4'd1;

  tx_state_t            state, state_next;
  logic [3:0]           cnt, cnt_next;
  logic                 transfer;
  logic                 tx_next;
  logic [WORD_BITS-1:0] hold;
  logic                 hold_full;
  logic [WORD_BITS-1:0] shifter;
  logic                 par_bit;
  logic                 first_half, half_strobe, bit_strobe;

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .restart    (state == ST_IDLE),
    .first_half (first_half),
    .half_strobe(half_strobe),
    .bit_strobe (bit_strobe)
  );

  // A word arriving in the same cycle the held word leaves is still taken.
  assign ready = ~hold_full | transfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt counts bits, except in the code violation where it counts half-bits.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    transfer   = 1'b0;
    tx_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          state_next = ST_QUIESCE;
          cnt_next   = '0;
        end
      end
      ST_QUIESCE: begin
        tx_next = manchester_half(1'b1, first_half);
        if (bit_strobe) begin
          if (cnt == QUIESCE_LAST) begin
            state_next = ST_CODE_VIOL;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end
      ST_CODE_VIOL: begin
        tx_next = (cnt >= CV_LOW_END);
        if (half_strobe) begin
          if (cnt == CV_LAST) begin
            state_next = ST_SYNC;
            cnt_next   = '0;
            transfer   = 1'b1;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end
      ST_SYNC: begin
        tx_next = manchester_half(1'b1, first_half);
        if (bit_strobe) begin
          state_next = ST_DATA;
          cnt_next   = '0;
        end
      end
      ST_DATA: begin
        tx_next = manchester_half(shifter[WORD_BITS-1], first_half);
        if (bit_strobe) begin
          if (cnt == DATA_LAST) begin
            state_next = ST_PARITY;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_next = manchester_half(par_bit, first_half);
        if (bit_strobe) begin
          cnt_next = '0;
          if (hold_full) begin
            state_next = ST_SYNC;
            transfer   = 1'b1;
          end else begin
            state_next = ST_END;
          end
        end
      end
      ST_END: begin
        tx_next = (cnt == '0) ? manchester_half(1'b0, first_half) : 1'b1;
        if (bit_strobe) begin
          if (cnt == END_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Holding register: capture on accepted load, drain on transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (load && ready) begin
      hold      <= data;
      hold_full <= 1'b1;
    end else if (transfer) begin
      hold_full <= 1'b0;
    end
  end

  // Parity is fixed at the moment the word enters the shifter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter <= '0;
      par_bit <= 1'b0;
    end else if (transfer) begin
      shifter <= hold;
      par_bit <= coax_parity(hold, parity);
    end else if (state == ST_DATA && bit_strobe) begin
      shifter <= {shifter[WORD_BITS-2:0], 1'b0};
    end
  end

  // Line outputs trail the sequencer by one clock so they come straight
  // from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx     <= 1'b0;
      active <= 1'b0;
    end else begin
      tx     <= tx_next;
      active <= (state != ST_IDLE);
    end
  end

`ifdef COAX_TX_DELAY_EN
  localparam int DELAY = CLOCKS_PER_BIT / 4;

  logic [DELAY-1:0] tx_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_pipe <= '0;
    end else begin
      tx_pipe[0] <= tx;
      for (int i = 1; i < DELAY; i++) begin
        tx_pipe[i] <= tx_pipe[i-1];
      end
    end
  end

  assign tx_delay = active & tx_pipe[DELAY-1];
`endif

endmodule

// File: tb/tb_coax_tx.sv
// tb_coax_tx -- self-checking bench for coax_tx.
// The reference builds each frame's expected line waveform from the frame
// format (half-bit levels expanded to clocks) and compares clock by clock.
module tb_coax_tx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data;
  logic       load;
  logic       ready;
  logic       parity;
  logic       tx;
  logic       active;
`ifdef COAX_TX_DELAY_EN
  logic       tx_delay;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic       exp_q[$];
  logic       cap_q[$];
  logic [9:0] words_q[$];
  int         load_at[$];

  coax_tx #(
    .CLOCKS_PER_BIT(CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .load  (load),
    .ready (ready),
    .parity(parity),
    .tx    (tx),
    .active(active)
`ifdef COAX_TX_DELAY_EN
    ,
    .tx_delay(tx_delay)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [9:0] d);
    load = l;
    data = d;
  endtask

  // Parity from the count of ones, sync bit included.
  function automatic logic refParity(input logic [9:0] w, input logic even);
    int ones;
    ones = $countones(w) + 1;
    return even ? ((ones % 2) == 1) : ((ones % 2) == 0);
  endfunction

  function automatic void pushHalf(input logic v);
    for (int k = 0; k < HALF; k++) exp_q.push_back(v);
  endfunction

  function automatic void pushBit(input logic b);
    pushHalf(!b);
    pushHalf(b);
  endfunction

  function automatic void buildModel(input logic par);
    exp_q.delete();
    for (int k = 0; k < 5; k++) pushBit(1'b1);
    for (int k = 0; k < 3; k++) pushHalf(1'b0);
    for (int k = 0; k < 3; k++) pushHalf(1'b1);
    foreach (words_q[w]) begin
      pushBit(1'b1);
      for (int b = 9; b >= 0; b--) pushBit(words_q[w][b]);
      pushBit(refParity(words_q[w], par));
    end
    pushBit(1'b0);
    pushHalf(1'b1);
    pushHalf(1'b1);
  endfunction

  // Sends words_q as one frame; extra words are loaded at load_at clocks,
  // and a load that must be refused is attempted at ignore_at (-1 = none).
  task automatic runFrame(input logic par, input int ignore_at);
    int next_w;
    int act_cnt;
    buildModel(par);
    cap_q.delete();
    parity = par;
    applyStimulus(1'b1, words_q[0]);
    @(negedge clk);
    applyStimulus(1'b0, '0);
    checkOutput("latency_n1_active", active, 0);
    @(negedge clk);
    checkOutput("latency_n2_active", active, 0);
    next_w  = 1;
    act_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      load = 1'b0;
      checkOutput("tx", tx, exp_q[i]);
      checkOutput("active", active, 1);
      if (active) act_cnt++;
      cap_q.push_back(tx);
`ifdef COAX_TX_DELAY_EN
      checkOutput("tx_delay", tx_delay, (i >= CPB / 4) ? exp_q[i - CPB/4] : 1'b0);
`endif
      if (next_w < words_q.size() && i == load_at[next_w-1]) begin
        checkOutput("ready_free", ready, 1);
        applyStimulus(1'b1, words_q[next_w]);
        next_w++;
      end
      if (i == ignore_at) begin
        checkOutput("ready_busy", ready, 0);
        applyStimulus(1'b1, ~words_q[0]);
      end
    end
    @(negedge clk);
    load = 1'b0;
    checkOutput("active_after", active, 0);
    checkOutput("tx_after", tx, 0);
    checkOutput("ready_after", ready, 1);
    checkOutput("active_clocks", act_cnt, (22 + 12 * (words_q.size() - 1)) * CPB);
  endtask

  initial begin
    logic [9:0] w;
    int         nw;
    reset  = 1'b1;
    load   = 1'b0;
    data   = '0;
    parity = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx, 0);
    checkOutput("reset_active", active, 0);
    checkOutput("reset_ready", ready, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single word 2AB, even parity");
    words_q = '{10'h2AB};
    load_at.delete();
    runFrame(1'b1, -1);
    checkOutput("parity_2AB", cap_q[19*CPB + HALF], 1);

    $display("[TB] back-to-back words 001, 3FF");
    words_q = '{10'h001, 10'h3FF};
    load_at = '{12 * CPB};
    runFrame(1'b1, -1);

    $display("[TB] word 000, odd parity");
    words_q = '{10'h000};
    load_at.delete();
    runFrame(1'b0, -1);
    checkOutput("parity_000_odd", cap_q[19*CPB + HALF], 0);

    $display("[TB] load while busy is ignored");
    w = 10'($urandom);
    words_q = '{w};
    runFrame(1'($urandom), 3 * CPB);

    $display("[TB] reset mid-frame");
    parity = 1'b1;
    applyStimulus(1'b1, 10'($urandom));
    @(negedge clk);
    load = 1'b0;
    repeat (51) @(negedge clk);
    checkOutput("pre_reset_active", active, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_tx", tx, 0);
    checkOutput("midreset_active", active, 0);
    checkOutput("midreset_ready", ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    words_q = '{10'h155};
    load_at.delete();
    runFrame(1'b1, -1);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      nw = int'($urandom_range(1, 3));
      words_q.delete();
      load_at.delete();
      for (int k = 0; k < nw; k++) words_q.push_back(10'($urandom));
      for (int k = 1; k < nw; k++)
        load_at.push_back((9 + 12 * (k - 1)) * CPB + int'($urandom_range(0, 9 * CPB)));
      runFrame(1'($urandom), -1);
      repeat (int'($urandom_range(0, 5))) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
